// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the system bus decoder: access sizes, FSM states,
// the alignment rule and the default ROM/RAM/MMIO address map.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hF000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] MMIO_MASK = 32'hF000_0000;

  // Size code 3 is never legal; halves need addr[0]==0, words addr[1:0]==0.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sys_bus_addr_decode.sv
// Combinational address-map decode: per-secondary match, lowest-index select
// and an overall hit flag.
module sys_bus_addr_decode
  import sys_bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SEC = 4,
  parameter int SW      = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1,
  parameter logic [NUM_SEC-1:0][WIDTH-1:0] BASE = '0,
  parameter logic [NUM_SEC-1:0][WIDTH-1:0] MASK = '0
) (
  input  logic [WIDTH-1:0] addr,
  output logic [SW-1:0]    sel,
  output logic             hit
);

  logic [NUM_SEC-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SEC; i++) begin
      match[i] = ((addr & MASK[i]) == BASE[i]);
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = NUM_SEC - 1; i >= 0; i--) begin
      if (match[i]) sel = SW'(i);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/sys_bus_decoder.sv
// One-primary-to-N-secondary bus decoder with wait-state handshake, request
// legality checks and a per-access timeout watchdog.
module sys_bus_decoder
  import sys_bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SEC = 4,
  parameter logic [NUM_SEC-1:0][WIDTH-1:0] BASE = '0,
  parameter logic [NUM_SEC-1:0][WIDTH-1:0] MASK = '0,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_wr,
  input  logic                     p_rd,
  input  logic [1:0]               p_size,
  input  logic [WIDTH-1:0]         p_addr,
  input  logic [WIDTH-1:0]         p_wdata,
  output logic [WIDTH-1:0]         p_rdata,
  output logic                     p_error,
  output logic                     p_ready,
  output logic [NUM_SEC-1:0]       s_wr,
  output logic [NUM_SEC-1:0]       s_rd,
  output logic [1:0]               s_size,
  output logic [WIDTH-1:0]         s_addr,
  output logic [WIDTH-1:0]         s_wdata,
  input  logic [NUM_SEC*WIDTH-1:0] s_rdata,
  input  logic [NUM_SEC-1:0]       s_error,
  input  logic [NUM_SEC-1:0]       s_ready
);

  localparam int SW = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     sel_q;
  logic              op_wr;

  logic [SW-1:0]      dec_sel;
  logic               dec_hit;
  logic               req;
  logic               illegal;
  logic [NUM_SEC-1:0] dec_onehot;
  logic               sec_ready;
  logic               sec_error;
  logic [WIDTH-1:0]   sec_rdata;
  logic               timed_out;

  sys_bus_addr_decode #(
    .WIDTH   (WIDTH),
    .NUM_SEC (NUM_SEC),
    .SW      (SW),
    .BASE    (BASE),
    .MASK    (MASK)
  ) u_decode (
    .addr (p_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  always_comb begin
    req        = p_rd | p_wr;
    illegal    = (p_rd & p_wr) | ~size_aligned(p_size, p_addr[1:0]) | ~dec_hit;
    dec_onehot = '0;
    dec_onehot[dec_sel] = 1'b1;
    sec_ready  = s_ready[sel_q];
    sec_error  = s_error[sel_q];
    sec_rdata  = s_rdata[int'(sel_q)*WIDTH +: WIDTH];
    timed_out  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      op_wr   <= 1'b0;
      p_rdata <= '0;
      p_error <= 1'b0;
      p_ready <= 1'b0;
      s_wr    <= '0;
      s_rd    <= '0;
      s_size  <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            s_addr  <= p_addr;
            s_size  <= p_size;
            s_wdata <= p_wdata;
            op_wr   <= p_wr;
            sel_q   <= dec_sel;
            cnt     <= '0;
            if (illegal) begin
              p_ready <= 1'b1;
              p_error <= 1'b1;
              p_rdata <= '0;
              state   <= RESP;
            end else begin
              s_rd  <= p_wr ? '0 : dec_onehot;
              s_wr  <= p_wr ? dec_onehot : '0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A ready arriving in the timeout cycle still completes normally.
          if (sec_ready) begin
            p_ready <= 1'b1;
            p_error <= sec_error;
            p_rdata <= op_wr ? '0 : sec_rdata;
            s_rd    <= '0;
            s_wr    <= '0;
            cnt     <= '0;
            state   <= RESP;
          end else if (timed_out) begin
            p_ready <= 1'b1;
            p_error <= 1'b1;
            p_rdata <= '0;
            s_rd    <= '0;
            s_wr    <= '0;
            cnt     <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          p_ready <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: begin
          p_ready <= 1'b0;
          s_rd    <= '0;
          s_wr    <= '0;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Directed bench for sys_bus_decoder: a two-secondary map driven through legal,
// illegal, wait-state, timeout and reset-abort accesses.
module tb_sys_bus_decoder;
  import sys_bus_pkg::*;

  localparam int W  = 32;
  localparam int NS = 2;
  localparam logic [NS-1:0][W-1:0] T_BASE = {32'h1000_0000, 32'h0000_0000};
  localparam logic [NS-1:0][W-1:0] T_MASK = {32'hF000_0000, 32'hFFFF_0000};

  logic          clk;
  logic          rst;
  logic          p_wr, p_rd;
  logic [1:0]    p_size;
  logic [W-1:0]  p_addr, p_wdata, p_rdata;
  logic          p_error, p_ready;
  logic [NS-1:0] s_wr, s_rd;
  logic [1:0]    s_size;
  logic [W-1:0]  s_addr, s_wdata;
  logic [NS*W-1:0] s_rdata;
  logic [NS-1:0] s_error, s_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  sys_bus_decoder #(
    .WIDTH(W), .NUM_SEC(NS), .BASE(T_BASE), .MASK(T_MASK), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .p_wr(p_wr), .p_rd(p_rd), .p_size(p_size),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_error(p_error),
    .p_ready(p_ready), .s_wr(s_wr), .s_rd(s_rd), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_error(s_error),
    .s_ready(s_ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver plus secondary model: the selected secondary raises ready after
  // `waits` strobe cycles; unselected secondaries hold ready/error high.
  task automatic do_access(
    input  logic rd, input logic wr, input logic [1:0] size,
    input  logic [W-1:0] addr, input logic [W-1:0] wdata,
    input  int sec, input int waits, input logic [W-1:0] rdata, input logic serr,
    output int lat, output int nstrobe,
    output logic [NS-1:0] rd_seen, output logic [NS-1:0] wr_seen,
    output logic [W-1:0] wdata_seen, output logic [1:0] size_seen,
    output logic [W-1:0] got_rdata, output logic got_err);
    logic got;
    p_rd = rd; p_wr = wr; p_size = size; p_addr = addr; p_wdata = wdata;
    s_rdata = {NS{32'hBAD0_BAD0}};
    s_rdata[sec*W +: W] = rdata;
    s_ready = ~(NS'(1) << sec);
    s_error = ~(NS'(1) << sec);
    if (serr) s_error[sec] = 1'b1;
    lat = 0; nstrobe = 0; rd_seen = '0; wr_seen = '0;
    wdata_seen = '0; size_seen = '0; got = 1'b0;
    got_rdata = '0; got_err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      lat++;
      if (p_ready) begin
        got = 1'b1;
        got_rdata = p_rdata;
        got_err = p_error;
        break;
      end
      if ((s_rd | s_wr) != '0) begin
        if (nstrobe == 0) begin
          wdata_seen = s_wdata;
          size_seen  = s_size;
        end
        nstrobe++;
        rd_seen |= s_rd;
        wr_seen |= s_wr;
        if (nstrobe >= waits + 1) s_ready[sec] = 1'b1;
      end
    end
    check("resp_seen", W'(got), 32'd1);
    p_rd = 1'b0; p_wr = 1'b0;
    s_ready = '0; s_error = '0;
  endtask

  int lat, nst;
  logic [NS-1:0] rds, wrs;
  logic [W-1:0] wds, rdat;
  logic [1:0] szs;
  logic err;

  initial begin
    rst = 1'b0; p_wr = 1'b0; p_rd = 1'b0; p_size = 2'd0;
    p_addr = '0; p_wdata = '0; s_rdata = '0; s_error = '0; s_ready = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p_ready", W'(p_ready), 32'd0);
    check("rst_p_error", W'(p_error), 32'd0);
    check("rst_p_rdata", p_rdata, 32'd0);
    check("rst_strobes", W'({s_rd, s_wr}), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_state", W'(dut.state), W'(IDLE));
    rst = 1'b0;
    tick();

    // Zero-wait word read from sec0
    exp_q.push_back(32'hDEAD_BEEF);
    do_access(1, 0, 2'd2, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("rd0_latency", W'(lat), 32'd2);
    check("rd0_strobe_cycles", W'(nst), 32'd1);
    check("rd0_s_rd", W'(rds), 32'b01);
    check("rd0_s_wr", W'(wrs), 32'b00);
    check("rd0_rdata", rdat, exp_q.pop_front());
    check("rd0_error", W'(err), 32'd0);
    tick();
    check("rd0_ready_pulse", W'(p_ready), 32'd0);
    check("rd0_rdata_hold", p_rdata, 32'hDEAD_BEEF);

    // Half write to sec1 with 3 wait states
    exp_q.push_back(32'h0);
    do_access(0, 1, 2'd1, 32'h1000_0002, 32'h0000_1234, 1, 3, 32'hAAAA_5555, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("wr1_latency", W'(lat), 32'd5);
    check("wr1_strobe_cycles", W'(nst), 32'd4);
    check("wr1_s_wr", W'(wrs), 32'b10);
    check("wr1_s_rd", W'(rds), 32'b00);
    check("wr1_s_wdata", wds, 32'h0000_1234);
    check("wr1_s_size", W'(szs), 32'd1);
    check("wr1_rdata", rdat, exp_q.pop_front());
    check("wr1_error", W'(err), 32'd0);
    tick();

    // Unmapped read
    do_access(1, 0, 2'd2, 32'h2000_0000, 32'h0, 0, 0, 32'h1, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("unmap_latency", W'(lat), 32'd1);
    check("unmap_strobes", W'(nst), 32'd0);
    check("unmap_error", W'(err), 32'd1);
    check("unmap_rdata", rdat, 32'd0);
    tick();
    check("unmap_error_hold", W'(p_error), 32'd1);

    // Misaligned word read
    do_access(1, 0, 2'd2, 32'h0000_0001, 32'h0, 0, 0, 32'h1, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("misal_latency", W'(lat), 32'd1);
    check("misal_strobes", W'(nst), 32'd0);
    check("misal_error", W'(err), 32'd1);
    tick();

    // Illegal size code
    do_access(1, 0, 2'd3, 32'h0000_0000, 32'h0, 0, 0, 32'h1, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("size3_error", W'(err), 32'd1);
    check("size3_strobes", W'(nst), 32'd0);
    tick();

    // Byte read at odd address is legal
    exp_q.push_back(32'h0000_00A5);
    do_access(1, 0, 2'd0, 32'h0000_0003, 32'h0, 0, 0, 32'h0000_00A5, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("byte_latency", W'(lat), 32'd2);
    check("byte_s_size", W'(szs), 32'd0);
    check("byte_rdata", rdat, exp_q.pop_front());
    check("byte_error", W'(err), 32'd0);
    tick();

    // Timeout on sec1 read with ready stuck low
    do_access(1, 0, 2'd2, 32'h1000_0000, 32'h0, 1, 1000, 32'h5555_AAAA, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("tmo_strobe_cycles", W'(nst), 32'd16);
    check("tmo_latency", W'(lat), 32'd17);
    check("tmo_s_rd", W'(rds), 32'b10);
    check("tmo_error", W'(err), 32'd1);
    check("tmo_rdata", rdat, 32'd0);
    tick();

    // Normal access after timeout
    exp_q.push_back(32'h0BAD_F00D);
    do_access(1, 0, 2'd2, 32'h1000_0004, 32'h0, 1, 1, 32'h0BAD_F00D, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("post_tmo_latency", W'(lat), 32'd3);
    check("post_tmo_rdata", rdat, exp_q.pop_front());
    check("post_tmo_error", W'(err), 32'd0);
    tick();

    // Both read and write asserted
    do_access(1, 1, 2'd2, 32'h0000_0010, 32'h0, 0, 0, 32'h1, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("rdwr_error", W'(err), 32'd1);
    check("rdwr_strobes", W'(nst), 32'd0);
    check("rdwr_latency", W'(lat), 32'd1);
    tick();

    // Secondary error with ready
    exp_q.push_back(32'h1111_2222);
    do_access(1, 0, 2'd2, 32'h0000_0004, 32'h0, 0, 0, 32'h1111_2222, 1,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("serr_error", W'(err), 32'd1);
    check("serr_rdata", rdat, exp_q.pop_front());
    tick();

    // Reset during an access wait state
    p_rd = 1'b1; p_size = 2'd2; p_addr = 32'h1000_0008; s_ready = '0;
    tick();
    tick();
    check("abort_s_rd_before", W'(s_rd), 32'b10);
    p_rd = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_s_rd_dropped", W'(s_rd), 32'd0);
    check("abort_state", W'(dut.state), W'(IDLE));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_ready", W'(p_ready), 32'd0);
      tick();
    end

    exp_q.push_back(32'hCAFE_0001);
    do_access(1, 0, 2'd2, 32'h0000_0020, 32'h0, 0, 0, 32'hCAFE_0001, 0,
              lat, nst, rds, wrs, wds, szs, rdat, err);
    check("post_rst_latency", W'(lat), 32'd2);
    check("post_rst_rdata", rdat, exp_q.pop_front());
    check("post_rst_error", W'(err), 32'd0);
    tick();
    check("exp_q_empty", W'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
